// File: rtl/nv_nvdla_nocif_dram_write_arb_pkg.sv
// Shared constants and FSM state type for the NOCIF DRAM write arbiter.
package nv_nvdla_nocif_dram_write_arb_pkg;

   localparam int ARB_NUM_CLI = 5;
   localparam int ARB_OS_W    = 9;
   localparam int WT_W        = 8;
   localparam int LEN_W       = 2;
   localparam int ID_W        = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GNT  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/nv_nvdla_nocif_dram_write_arb_rr_pick.sv
// Round-robin picker: first eligible client at or after rr_ptr, wrapping modulo NUM_CLI.
module nv_nvdla_nocif_dram_write_arb_rr_pick
   import nv_nvdla_nocif_dram_write_arb_pkg::*;
#(
   parameter int NUM_CLI = ARB_NUM_CLI
) (
   input  logic [NUM_CLI-1:0] eligible,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    winner,
   output logic               found
);

   localparam logic [ID_W:0] NUM_CLI_W = (ID_W+1)'(NUM_CLI);

   logic [ID_W:0] idx;

   // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      // Scan farthest-first so the closest eligible client to rr_ptr is the last one written.
      for (int k = NUM_CLI - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx >= NUM_CLI_W) idx = idx - NUM_CLI_W;
         if (eligible[idx[ID_W-1:0]]) begin
            winner = idx[ID_W-1:0];
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nv_nvdla_nocif_dram_write_arb.sv
// Weighted round-robin DRAM write arbiter with outstanding-beat credit gating.
module nv_nvdla_nocif_dram_write_arb
   import nv_nvdla_nocif_dram_write_arb_pkg::*;
#(
   parameter int NUM_CLI = ARB_NUM_CLI,
   parameter int OS_W    = ARB_OS_W
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rstn,
   input  logic [NUM_CLI-1:0]       cli_req_vld,
   input  logic [LEN_W*NUM_CLI-1:0] cli_req_len,
   input  logic [WT_W*NUM_CLI-1:0]  cli_wt,
   output logic [NUM_CLI-1:0]       cli_req_rdy,
   input  logic [7:0]               reg2dp_wr_os_cnt,
   output logic                     arb_gnt_vld,
   output logic [ID_W-1:0]          arb_gnt_id,
   output logic [LEN_W-1:0]         arb_gnt_len,
   input  logic                     arb_gnt_rdy,
   input  logic                     eg2ig_axi_vld,
   input  logic [LEN_W-1:0]         eg2ig_axi_len,
   output logic [OS_W-1:0]          os_cnt_cur,
   output logic                     os_underflow
);

   arb_state_e       state;
   logic [WT_W-1:0]  credit  [NUM_CLI];
   logic [WT_W-1:0]  wt      [NUM_CLI];
   logic [LEN_W-1:0] req_len [NUM_CLI];
   logic [ID_W-1:0]  rr_ptr;
   logic [OS_W-1:0]  os_cnt;

   logic [NUM_CLI-1:0] wanting;
   logic [NUM_CLI-1:0] eligible;
   logic [ID_W-1:0]    winner;
   logic               found;
   logic [LEN_W-1:0]   win_len;
   logic               credit_ok;
   logic               accept;
   logic [2:0]         gnt_beats;
   logic [2:0]         ret_beats;
   logic [OS_W:0]      os_sum;
   logic               os_below;
   logic [OS_W-1:0]    os_nxt;

   always_comb begin
      for (int i = 0; i < NUM_CLI; i++) begin
         wt[i]       = cli_wt[i*WT_W +: WT_W];
         req_len[i]  = cli_req_len[i*LEN_W +: LEN_W];
         wanting[i]  = cli_req_vld[i] & (|wt[i]);
         eligible[i] = wanting[i] & (|credit[i]);
      end
   end

   nv_nvdla_nocif_dram_write_arb_rr_pick #(
      .NUM_CLI (NUM_CLI)
   ) u_rr_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .winner   (winner),
      .found    (found)
   );

   assign win_len   = req_len[winner];
   // os + beats <= limit + 1 with both sides' +1 cancelled.
   assign credit_ok = ((OS_W+1)'(os_cnt) + (OS_W+1)'(win_len)) <= (OS_W+1)'(reg2dp_wr_os_cnt);
   assign accept    = arb_gnt_vld & arb_gnt_rdy;

   assign gnt_beats = {1'b0, arb_gnt_len} + 3'd1;
   assign ret_beats = {1'b0, eg2ig_axi_len} + 3'd1;
   assign os_sum    = {1'b0, os_cnt} + (OS_W+1)'(accept ? gnt_beats : 3'd0);
   assign os_below  = eg2ig_axi_vld && (os_sum < (OS_W+1)'(ret_beats));
   assign os_nxt    = os_below      ? '0 :
                      eg2ig_axi_vld ? OS_W'(os_sum - (OS_W+1)'(ret_beats)) : OS_W'(os_sum);
   assign os_cnt_cur = os_cnt;

   always_comb begin
      cli_req_rdy = '0;
      if (accept) cli_req_rdy[arb_gnt_id] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state        <= ST_IDLE;
         arb_gnt_vld  <= 1'b0;
         arb_gnt_id   <= '0;
         arb_gnt_len  <= '0;
         rr_ptr       <= '0;
         os_cnt       <= '0;
         os_underflow <= 1'b0;
         // NOTE: the credit array is true state, not storage: zero credits force a reload on the first request.
         for (int i = 0; i < NUM_CLI; i++) credit[i] <= '0;
      end else begin
         os_cnt <= os_nxt;
         if (os_below) os_underflow <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (found) begin
                  // A blocked winner stalls arbitration rather than letting another client pass it.
                  if (credit_ok) begin
                     state       <= ST_GNT;
                     arb_gnt_vld <= 1'b1;
                     arb_gnt_id  <= winner;
                     arb_gnt_len <= win_len;
                  end
               end else if (|wanting) begin
                  for (int i = 0; i < NUM_CLI; i++) credit[i] <= wt[i];
               end
            end
            ST_GNT: begin
               if (arb_gnt_rdy) begin
                  state              <= ST_IDLE;
                  arb_gnt_vld        <= 1'b0;
                  credit[arb_gnt_id] <= credit[arb_gnt_id] - WT_W'(1);
                  rr_ptr             <= (arb_gnt_id == ID_W'(NUM_CLI - 1)) ? '0 : arb_gnt_id + ID_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nv_nvdla_nocif_dram_write_arb.sv
// Directed and randomized bench for the DRAM write arbiter against a behavioural model.
module tb_nv_nvdla_nocif_dram_write_arb;

   localparam int NUM_CLI = 5;
   localparam int OS_W    = 9;

   logic                   clk;
   logic                   rst_n;
   logic [NUM_CLI-1:0]     cli_req_vld;
   logic [2*NUM_CLI-1:0]   cli_req_len;
   logic [8*NUM_CLI-1:0]   cli_wt;
   logic [NUM_CLI-1:0]     cli_req_rdy;
   logic [7:0]             reg2dp_wr_os_cnt;
   logic                   arb_gnt_vld;
   logic [2:0]             arb_gnt_id;
   logic [1:0]             arb_gnt_len;
   logic                   arb_gnt_rdy;
   logic                   eg2ig_axi_vld;
   logic [1:0]             eg2ig_axi_len;
   logic [OS_W-1:0]        os_cnt_cur;
   logic                   os_underflow;

   nv_nvdla_nocif_dram_write_arb #(
      .NUM_CLI (NUM_CLI),
      .OS_W    (OS_W)
   ) dut (
      .nvdla_core_clk   (clk),
      .nvdla_core_rstn  (rst_n),
      .cli_req_vld      (cli_req_vld),
      .cli_req_len      (cli_req_len),
      .cli_wt           (cli_wt),
      .cli_req_rdy      (cli_req_rdy),
      .reg2dp_wr_os_cnt (reg2dp_wr_os_cnt),
      .arb_gnt_vld      (arb_gnt_vld),
      .arb_gnt_id       (arb_gnt_id),
      .arb_gnt_len      (arb_gnt_len),
      .arb_gnt_rdy      (arb_gnt_rdy),
      .eg2ig_axi_vld    (eg2ig_axi_vld),
      .eg2ig_axi_len    (eg2ig_axi_len),
      .os_cnt_cur       (os_cnt_cur),
      .os_underflow     (os_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int gnt_log[$];
   int rdy_pulses;

   // Reference model: one outstanding grant, per-client credits, rotating pointer, beat count.
   bit m_busy;
   bit m_uf;
   int m_id, m_len, m_ptr, m_os;
   int m_cred[NUM_CLI];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wt_of(input int i);
      return int'(cli_wt[i*8 +: 8]);
   endfunction

   function automatic int len_of(input int i);
      return int'(cli_req_len[i*2 +: 2]);
   endfunction

   task automatic model_reset();
      m_busy = 0; m_uf = 0; m_id = 0; m_len = 0; m_ptr = 0; m_os = 0;
      for (int i = 0; i < NUM_CLI; i++) m_cred[i] = 0;
   endtask

   task automatic model_step();
      int inc, dec, w, idx;
      bit any_want;
      inc = 0; dec = 0;
      if (m_busy) begin
         if (arb_gnt_rdy) begin
            m_busy = 0;
            m_cred[m_id] = m_cred[m_id] - 1;
            m_ptr = (m_id + 1) % NUM_CLI;
            inc = m_len + 1;
         end
      end else begin
         w = -1; any_want = 0;
         for (int k = 0; k < NUM_CLI; k++) begin
            idx = (m_ptr + k) % NUM_CLI;
            if (cli_req_vld[idx] && wt_of(idx) != 0) begin
               any_want = 1;
               if (m_cred[idx] > 0 && w < 0) w = idx;
            end
         end
         if (w >= 0) begin
            if (m_os + len_of(w) + 1 <= int'(reg2dp_wr_os_cnt) + 1) begin
               m_busy = 1; m_id = w; m_len = len_of(w);
            end
         end else if (any_want) begin
            for (int i = 0; i < NUM_CLI; i++) m_cred[i] = wt_of(i);
         end
      end
      if (eg2ig_axi_vld) dec = int'(eg2ig_axi_len) + 1;
      m_os = m_os + inc - dec;
      if (m_os < 0) begin
         m_os = 0; m_uf = 1;
      end
   endtask

   // Called at a falling edge with inputs already applied; compares, advances the model, clocks once.
   task automatic step();
      logic [31:0] exp_rdy;
      #1;
      exp_rdy = (m_busy && arb_gnt_rdy) ? (32'd1 << m_id) : 32'd0;
      check("gnt_vld", 32'(arb_gnt_vld), 32'(m_busy));
      check("gnt_id", 32'(arb_gnt_id), m_id);
      check("gnt_len", 32'(arb_gnt_len), m_len);
      check("req_rdy", 32'(cli_req_rdy), exp_rdy);
      check("os_cnt", 32'(os_cnt_cur), m_os);
      check("underflow", 32'(os_underflow), 32'(m_uf));
      if (arb_gnt_vld && arb_gnt_rdy) gnt_log.push_back(int'(arb_gnt_id));
      rdy_pulses += $countones(cli_req_rdy);
      model_step();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_gnt(input string tag, input int budget);
      for (int k = 0; k < budget && !arb_gnt_vld; k++) step();
      check(tag, 32'(arb_gnt_vld), 32'd1);
   endtask

   task automatic idle_inputs();
      cli_req_vld = '0; cli_req_len = '0; cli_wt = '0;
      reg2dp_wr_os_cnt = 8'd255; arb_gnt_rdy = 1'b0;
      eg2ig_axi_vld = 1'b0; eg2ig_axi_len = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      gnt_log.delete();
      rdy_pulses = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_all_wt(input int w);
      for (int i = 0; i < NUM_CLI; i++) cli_wt[i*8 +: 8] = 8'(w);
   endtask

   initial begin
      int cnt0, cnt1, cnt_other;
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      rdy_pulses = 0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_gnt_vld", 32'(arb_gnt_vld), 32'd0);
      check("rst_gnt_id", 32'(arb_gnt_id), 32'd0);
      check("rst_gnt_len", 32'(arb_gnt_len), 32'd0);
      check("rst_req_rdy", 32'(cli_req_rdy), 32'd0);
      check("rst_os_cnt", 32'(os_cnt_cur), 32'd0);
      check("rst_underflow", 32'(os_underflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Equal weights: plain rotation, then a reload and back to client 0.
      set_all_wt(1);
      cli_req_vld = '1;
      arb_gnt_rdy = 1'b1;
      run(14);
      check("rot_count", gnt_log.size(), 32'd6);
      for (int i = 0; i < 6; i++) check("rot_id", gnt_log[i], (i == 5) ? 0 : i);

      // 3:1 weighting; masked clients keep requesting but are never served.
      idle_inputs();
      do_reset();
      cli_wt[7:0] = 8'd3;
      cli_wt[15:8] = 8'd1;
      cli_req_vld = '1;
      arb_gnt_rdy = 1'b1;
      for (int k = 0; k < 200 && gnt_log.size() < 40; k++) step();
      check("wrr_count", gnt_log.size(), 32'd40);
      check("wrr_seq0", gnt_log[0], 32'd0);
      check("wrr_seq1", gnt_log[1], 32'd1);
      check("wrr_seq2", gnt_log[2], 32'd0);
      check("wrr_seq3", gnt_log[3], 32'd0);
      cnt0 = 0; cnt1 = 0; cnt_other = 0;
      foreach (gnt_log[i]) begin
         if (gnt_log[i] == 0) cnt0++;
         else if (gnt_log[i] == 1) cnt1++;
         else cnt_other++;
      end
      check("wrr_share0", cnt0, 32'd30);
      check("wrr_share1", cnt1, 32'd10);
      check("wrr_masked", cnt_other, 32'd0);

      // Outstanding-beat limit of 4 with 4-beat bursts: one grant until a retire frees beats.
      idle_inputs();
      do_reset();
      reg2dp_wr_os_cnt = 8'd3;
      cli_wt[7:0] = 8'd4;
      cli_req_len[1:0] = 2'd3;
      cli_req_vld = 5'b00001;
      arb_gnt_rdy = 1'b1;
      wait_gnt("gate_first", 10);
      step();
      run(10);
      check("gate_stall_cnt", gnt_log.size(), 32'd1);
      check("gate_os_full", 32'(os_cnt_cur), 32'd4);
      eg2ig_axi_vld = 1'b1;
      eg2ig_axi_len = 2'd3;
      step();
      eg2ig_axi_vld = 1'b0;
      run(6);
      check("gate_resume_cnt", gnt_log.size(), 32'd2);

      // Backpressure: grant held five cycles, exactly one ready pulse on release.
      idle_inputs();
      do_reset();
      set_all_wt(1);
      cli_req_len[1:0] = 2'd2;
      cli_req_vld = 5'b00001;
      wait_gnt("bp_gnt", 10);
      rdy_pulses = 0;
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_vld", 32'(arb_gnt_vld), 32'd1);
         check("bp_hold_id", 32'(arb_gnt_id), 32'd0);
         check("bp_hold_len", 32'(arb_gnt_len), 32'd2);
         step();
      end
      arb_gnt_rdy = 1'b1;
      step();
      cli_req_vld = '0;
      arb_gnt_rdy = 1'b0;
      run(3);
      check("bp_pulses", rdy_pulses, 32'd1);

      // Acceptance of a 2-beat grant coinciding with a 4-beat retire from count 4.
      idle_inputs();
      do_reset();
      cli_wt[7:0] = 8'd4;
      cli_wt[15:8] = 8'd1;
      cli_req_len[1:0] = 2'd3;
      cli_req_len[3:2] = 2'd1;
      cli_req_vld = 5'b00001;
      arb_gnt_rdy = 1'b1;
      wait_gnt("sim_first", 10);
      step();
      cli_req_vld = 5'b00010;
      arb_gnt_rdy = 1'b0;
      wait_gnt("sim_second", 10);
      check("sim_id", 32'(arb_gnt_id), 32'd1);
      check("sim_os_before", 32'(os_cnt_cur), 32'd4);
      arb_gnt_rdy = 1'b1;
      eg2ig_axi_vld = 1'b1;
      eg2ig_axi_len = 2'd3;
      step();
      idle_inputs();
      check("sim_os_after", 32'(os_cnt_cur), 32'd2);

      // Retire at zero saturates and latches the error flag.
      do_reset();
      eg2ig_axi_vld = 1'b1;
      eg2ig_axi_len = 2'd0;
      step();
      eg2ig_axi_vld = 1'b0;
      check("uf_os", 32'(os_cnt_cur), 32'd0);
      check("uf_flag", 32'(os_underflow), 32'd1);

      // Reset while a grant is pending clears everything before the next edge.
      cli_wt[7:0] = 8'd1;
      cli_req_len[1:0] = 2'd1;
      cli_req_vld = 5'b00001;
      arb_gnt_rdy = 1'b1;
      wait_gnt("rstg_first", 10);
      step();
      arb_gnt_rdy = 1'b0;
      wait_gnt("rstg_second", 10);
      check("rstg_os_before", 32'(os_cnt_cur), 32'd2);
      #2;
      rst_n = 1'b0;
      arb_gnt_rdy = 1'b1;
      #1;
      check("rstg_gnt_vld", 32'(arb_gnt_vld), 32'd0);
      check("rstg_gnt_id", 32'(arb_gnt_id), 32'd0);
      check("rstg_gnt_len", 32'(arb_gnt_len), 32'd0);
      check("rstg_req_rdy", 32'(cli_req_rdy), 32'd0);
      check("rstg_os", 32'(os_cnt_cur), 32'd0);
      check("rstg_uf", 32'(os_underflow), 32'd0);
      idle_inputs();
      @(negedge clk);
      do_reset();

      // Randomized traffic, weight changes, limit changes and retires against the model.
      set_all_wt(1);
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         cli_req_vld = NUM_CLI'($urandom);
         cli_req_len = (2*NUM_CLI)'($urandom);
         if ($urandom_range(0, 19) == 0)
            for (int i = 0; i < NUM_CLI; i++) cli_wt[i*8 +: 8] = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0)
            reg2dp_wr_os_cnt = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'd255;
         arb_gnt_rdy = ($urandom_range(0, 3) != 0);
         eg2ig_axi_vld = ($urandom_range(0, 3) == 0);
         eg2ig_axi_len = 2'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
